// File: rtl/ex_muldiv.sv
// Execute-stage multiply/divide unit owning the architectural HI/LO registers.
// The divider is built only when MULDIV_DIV_EN is defined; otherwise DIV/DIVU are no-ops.
module ex_muldiv #(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        flush,
    input  logic [5:0]  ex_opcode,
    input  logic [5:0]  ex_func,
    input  logic [31:0] ex_rdata_a,
    input  logic [31:0] ex_rdata_b,
    output logic        muldiv_stall,
    output logic [31:0] hilo_rdata,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] FN_MFHI    = 6'b010000;
    localparam logic [5:0] FN_MTHI    = 6'b010001;
    localparam logic [5:0] FN_MFLO    = 6'b010010;
    localparam logic [5:0] FN_MTLO    = 6'b010011;
    localparam logic [5:0] FN_MULT    = 6'b011000;
    localparam logic [5:0] FN_MULTU   = 6'b011001;
    localparam logic [5:0] FN_DIV     = 6'b011010;
    localparam logic [5:0] FN_DIVU    = 6'b011011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
`ifdef MULDIV_DIV_EN
        DIV  = 2'd2,
`endif
        DONE = 2'd3
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] hi_reg, hi_next;
    logic [31:0] lo_reg, lo_next;
    logic [31:0] opa_reg, opa_next;   // multiplicand, or dividend shifting into quotient
    logic [31:0] opb_reg, opb_next;
    logic        neg_res_reg, neg_res_next;

    logic        is_special;
    logic        op_mul;
    logic        op_signed;
    logic        accept;
    logic        start;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [63:0] product;
    logic [63:0] product_fix;

    assign is_special = (ex_opcode == OP_SPECIAL);
    assign op_mul     = is_special && (ex_func == FN_MULT || ex_func == FN_MULTU);
    assign op_signed  = (ex_func == FN_MULT) || (ex_func == FN_DIV);
    assign accept     = (state_reg == IDLE) && ex_valid && !flush;
    assign abs_a      = (op_signed && ex_rdata_a[31]) ? -ex_rdata_a : ex_rdata_a;
    assign abs_b      = (op_signed && ex_rdata_b[31]) ? -ex_rdata_b : ex_rdata_b;

    assign product     = {32'd0, opa_reg} * {32'd0, opb_reg};
    assign product_fix = neg_res_reg ? -product : product;

`ifdef MULDIV_DIV_EN
    localparam logic [4:0] DIV_LAST = 5'(DIV_CYCLES - 1);

    logic        op_div;
    logic        neg_rem_reg, neg_rem_next;
    logic [31:0] rem_reg, rem_next;
    logic [4:0]  count_reg, count_next;
    logic [32:0] shifted;
    logic [32:0] trial;
    logic [31:0] step_rem;
    logic [31:0] step_quo;

    assign op_div = is_special && (ex_func == FN_DIV || ex_func == FN_DIVU);
    assign start  = accept && (op_mul || op_div);

    // Restoring step: the partial remainder stays below the divisor, so bit 32 of
    // the trial difference is a reliable borrow flag.
    assign shifted  = {rem_reg, opa_reg[31]};
    assign trial    = shifted - {1'b0, opb_reg};
    assign step_rem = trial[32] ? shifted[31:0] : trial[31:0];
    assign step_quo = {opa_reg[30:0], ~trial[32]};

    assign muldiv_stall = start || (state_reg == MUL) || (state_reg == DIV);
`else
    assign start        = accept && op_mul;
    assign muldiv_stall = start || (state_reg == MUL);
`endif

    always_comb begin
        hilo_rdata = 32'd0;
        if (ex_valid && is_special) begin
            if (ex_func == FN_MFHI) begin
                hilo_rdata = hi_reg;
            end else if (ex_func == FN_MFLO) begin
                hilo_rdata = lo_reg;
            end
        end
    end

    always_comb begin
        state_next   = state_reg;
        hi_next      = hi_reg;
        lo_next      = lo_reg;
        opa_next     = opa_reg;
        opb_next     = opb_reg;
        neg_res_next = neg_res_reg;
`ifdef MULDIV_DIV_EN
        neg_rem_next = neg_rem_reg;
        rem_next     = rem_reg;
        count_next   = count_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (accept && is_special) begin
                    if (ex_func == FN_MTHI) begin
                        hi_next = ex_rdata_a;
                    end
                    if (ex_func == FN_MTLO) begin
                        lo_next = ex_rdata_a;
                    end
                    if (start) begin
                        opa_next     = abs_a;
                        opb_next     = abs_b;
                        neg_res_next = op_signed && (ex_rdata_a[31] ^ ex_rdata_b[31]);
                        state_next   = MUL;
`ifdef MULDIV_DIV_EN
                        neg_rem_next = op_signed && ex_rdata_a[31];
                        rem_next     = 32'd0;
                        count_next   = 5'd0;
                        if (op_div) begin
                            state_next = (ex_rdata_b == 32'd0) ? DONE : DIV;
                        end
`endif
                    end
                end
            end
            MUL: begin
                if (flush) begin
                    state_next = IDLE;
                end else begin
                    hi_next    = product_fix[63:32];
                    lo_next    = product_fix[31:0];
                    state_next = DONE;
                end
            end
`ifdef MULDIV_DIV_EN
            DIV: begin
                if (flush) begin
                    state_next = IDLE;
                end else begin
                    rem_next   = step_rem;
                    opa_next   = step_quo;
                    count_next = count_reg + 5'd1;
                    if (count_reg == DIV_LAST) begin
                        hi_next    = neg_rem_reg ? -step_rem : step_rem;
                        lo_next    = neg_res_reg ? -step_quo : step_quo;
                        state_next = DONE;
                    end
                end
            end
`endif
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            hi_reg      <= 32'd0;
            lo_reg      <= 32'd0;
            opa_reg     <= 32'd0;
            opb_reg     <= 32'd0;
            neg_res_reg <= 1'b0;
`ifdef MULDIV_DIV_EN
            neg_rem_reg <= 1'b0;
            rem_reg     <= 32'd0;
            count_reg   <= 5'd0;
`endif
        end else begin
            state_reg   <= state_next;
            hi_reg      <= hi_next;
            lo_reg      <= lo_next;
            opa_reg     <= opa_next;
            opb_reg     <= opb_next;
            neg_res_reg <= neg_res_next;
`ifdef MULDIV_DIV_EN
            neg_rem_reg <= neg_rem_next;
            rem_reg     <= rem_next;
            count_reg   <= count_next;
`endif
        end
    end

    assign hi = hi_reg;
    assign lo = lo_reg;

endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Execute-stage multiply/divide unit with architectural HI/LO registers. It consumes the operands and opcode/func fields produced by the ID/EX pipeline register, executes MULT/MULTU/DIV/DIVU as multi-cycle operations and MTHI/MTLO/MFHI/MFLO as single-cycle operations. While an operation is in flight it asserts a stall that holds PC, IF/ID and ID/EX.

## Interface
Parameters:
- DIV_CYCLES, 32, number of divider iterations. Fixed at 32; other values are unsupported.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- ex_valid  input  1  EX holds a real instruction (0 = bubble).
- flush  input  1  synchronous kill of the EX instruction and any in-flight operation.
- ex_opcode  input  6  instruction opcode; only 6'b000000 (SPECIAL) is decoded.
- ex_func  input  6  function field.
- ex_rdata_a  input  32  rs operand (multiplicand/dividend; MTHI/MTLO source).
- ex_rdata_b  input  32  rt operand (multiplier/divisor).
- muldiv_stall  output  1  hold upstream stages and ID/EX.
- hilo_rdata  output  32  combinational HI (MFHI) or LO (MFLO) value; 0 otherwise.
- hi  output  32  HI register.
- lo  output  32  LO register.

## Operation
- Decoded func codes, used only when opcode is SPECIAL:
  - MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011.
  - MULT 011000, MULTU 011001, DIV 011010, DIVU 011011.
- Start condition: state IDLE, ex_valid=1, flush=0, func is one of MULT/MULTU/DIV/DIVU.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE → MUL on start with MULT/MULTU.
  - IDLE → DIV on start with DIV/DIVU when the divisor is nonzero.
  - IDLE → DONE on DIV/DIVU with divisor 0. HI/LO are unchanged.
  - MUL → DONE after 1 cycle. Writes HI = product[63:32], LO = product[31:0].
  - DIV → DONE when count == 31. Writes HI = remainder, LO = quotient.
  - DONE → IDLE unconditionally. A start is never accepted in DONE.
- On start, operands are latched.
  - Signed ops latch absolute values plus the result signs.
  - Quotient sign = a[31]^b[31]; remainder sign = a[31]; product sign = a[31]^b[31].
- Divider: restoring, one quotient bit per cycle, 5-bit count from 0 to 31.
- Arithmetic width rules:
  - Product is the 64-bit result, two's-complement negated if the sign is set.
  - Signed results wrap. 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0.
- MTHI/MTLO: write ex_rdata_a into HI/LO at the clock edge when IDLE, ex_valid=1 and flush=0.
- MFHI/MFLO: hilo_rdata reflects the current register value with no bypass. This is correct because every write completes before the next instruction enters EX.
- Flush:
  - From MUL or DIV, state → IDLE and HI/LO are not written.
  - In IDLE, a pending MTHI/MTLO/start is suppressed.
  - In DONE, flush has no effect; HI/LO are already committed.
- Reset values: state IDLE, hi=0, lo=0, count=0, muldiv_stall=0, hilo_rdata=0.
  - Reset mid-operation abandons the operation with no HI/LO write.

## Timing
- muldiv_stall = start condition (combinational) OR state ∈ {MUL, DIV}. It is low in DONE and IDLE otherwise.
- MULT/MULTU: stall high 2 cycles (accept + MUL). EX occupancy is 3 cycles. HI/LO are visible from the DONE cycle.
- DIV/DIVU: stall high 33 cycles (accept + 32 DIV). EX occupancy is 34 cycles.
- DIV/DIVU by zero: stall high 1 cycle (accept). DONE follows; HI/LO are unchanged.
- MTHI/MTLO: no stall. The new value is readable by MFHI/MFLO in the very next cycle.
- Back-to-back MULT after DONE: the next instruction arrives in the cycle after DONE and starts normally from IDLE.

## Configuration
- MULDIV_DIV_EN defined: the divider and the DIV state are present, as described above.
- MULDIV_DIV_EN undefined:
  - No divider logic and no DIV state.
  - DIV/DIVU behave as a no-op: no stall, HI/LO unchanged.
  - MULT/MULTU, MTHI/MTLO and MFHI/MFLO are unaffected.

## Test plan
- MULT, a=0xFFFFFFFE (-2), b=3 → stall high exactly 2 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MULTU, a=0xFFFFFFFF, b=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- DIV, a=0xFFFFFFF9 (-7), b=2 → stall 33 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU, a=100, b=7 → LO=14, HI=2.
- DIV by zero with HI=0x11, LO=0x22 preloaded → 1 stall cycle; HI/LO unchanged.
- Divide-time edge cases:
  - Flush asserted at DIV cycle 10 → state IDLE next cycle, stall drops, HI/LO unchanged.
  - Async rst asserted mid-MUL → hi=lo=0 immediately, stall=0.
- HI/LO move path: MTHI 0xDEADBEEF then MFHI in the next cycle → hilo_rdata=0xDEADBEEF, no stall.
  - With MULDIV_DIV_EN undefined, DIVU 100/7 → no stall, HI/LO unchanged.
